// File: rtl/uart_sync_fifo_pkg.sv
// Shared UART FIFO definitions: default geometry used by the TX/RX buffers
// and a constant-foldable ceil(log2) helper.
package uart_sync_fifo_pkg;

  localparam int unsigned UART_FIFO_DATA_W = 8;
  localparam int unsigned UART_FIFO_DEPTH  = 16;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Parametrised synchronous FIFO between the UART engines and the bus side,
// with occupancy, thresholds, sticky errors, flush and optional FWFT reads.
module uart_sync_fifo
  import uart_sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = UART_FIFO_DATA_W,
  parameter int unsigned DEPTH    = UART_FIFO_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = 0,
  localparam int unsigned AW      = clog2(DEPTH),
  localparam int unsigned LW      = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_en,
  input  logic              i_rd_en,
  input  logic              i_flush,
  input  logic              i_clr_err,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_almost_empty,
  output logic              o_almost_full,
  output logic [LW-1:0]     o_level,
  output logic              o_overflow,
  output logic              o_underflow
);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_sync_fifo: DEPTH must be a power of two and at least 4");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("uart_sync_fifo: AF_LEVEL must not exceed DEPTH");
  end
  if (AE_LEVEL >= DEPTH) begin : g_bad_ae
    $error("uart_sync_fifo: AE_LEVEL must be below DEPTH");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]     r_level, w_level_d;
  logic              r_empty, r_full, r_almost_empty, r_almost_full;
  logic              r_overflow, r_underflow;
  logic [DATA_W-1:0] r_rd_data, w_head;
  logic              r_rd_valid;
  logic              w_push_ok, w_pop_ok;

  // Acceptance uses the registered flags; flush suppresses both sides.
  assign w_push_ok = i_wr_en & ~r_full & ~i_flush;
  assign w_pop_ok  = i_rd_en & ~r_empty & ~i_flush;
  assign w_head    = r_mem[r_rd_ptr];

  always_comb begin
    w_level_d = r_level;
    if (i_flush) begin
      w_level_d = '0;
    end else if (w_push_ok && !w_pop_ok) begin
      w_level_d = r_level + LW'(1);
    end else if (w_pop_ok && !w_push_ok) begin
      w_level_d = r_level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_empty <= 1'b1;
      r_almost_full  <= 1'b0;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
      r_rd_data      <= '0;
      r_rd_valid     <= 1'b0;
    end else begin
      r_level        <= w_level_d;
      r_empty        <= (w_level_d == '0);
      r_full         <= (w_level_d == LW'(DEPTH));
      r_almost_empty <= (w_level_d <= LW'(AE_LEVEL));
      r_almost_full  <= (w_level_d >= LW'(AF_LEVEL));
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_rd_valid <= w_pop_ok && (FWFT == 0);
      // In FWFT mode the visible head is latched on flush so rd_data holds.
      if (w_pop_ok || (i_flush && (FWFT != 0) && !r_empty)) r_rd_data <= w_head;
      r_overflow  <= (i_wr_en & r_full & ~i_flush) | (r_overflow & ~i_clr_err);
      r_underflow <= (i_rd_en & r_empty & ~i_flush) | (r_underflow & ~i_clr_err);
    end
  end

  assign o_rd_data      = ((FWFT != 0) && !r_empty) ? w_head : r_rd_data;
  assign o_rd_valid     = (FWFT != 0) ? ~r_empty : r_rd_valid;
  assign o_empty        = r_empty;
  assign o_full         = r_full;
  assign o_almost_empty = r_almost_empty;
  assign o_almost_full  = r_almost_full;
  assign o_level        = r_level;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Bench for uart_sync_fifo: directed table, corner sequences and a randomized
// run against a queue model, on a registered-read and an FWFT instance.
module tb_uart_sync_fifo;

  localparam int DEPTH = 16;
  localparam int AFL   = 14;
  localparam int AEL   = 2;

  logic       clk, reset;
  logic       wr_en, rd_en, flush, clr_err;
  logic [7:0] wr_data;
  logic [7:0] rd_data0, rd_data1;
  logic       rd_valid0, rd_valid1, empty0, empty1, full0, full1;
  logic       ae0, ae1, af0, af1, ovf0, ovf1, unf0, unf1;
  logic [4:0] level0, level1;

  int n_tests;
  int n_fail;

  uart_sync_fifo #(
    .DATA_W(8), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .i_wr_data(wr_data), .i_wr_en(wr_en), .i_rd_en(rd_en),
    .i_flush(flush), .i_clr_err(clr_err), .o_rd_data(rd_data0), .o_rd_valid(rd_valid0),
    .o_empty(empty0), .o_full(full0), .o_almost_empty(ae0), .o_almost_full(af0),
    .o_level(level0), .o_overflow(ovf0), .o_underflow(unf0)
  );

  uart_sync_fifo #(
    .DATA_W(8), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .i_wr_data(wr_data), .i_wr_en(wr_en), .i_rd_en(rd_en),
    .i_flush(flush), .i_clr_err(clr_err), .o_rd_data(rd_data1), .o_rd_valid(rd_valid1),
    .o_empty(empty1), .o_full(full1), .o_almost_empty(ae1), .o_almost_full(af1),
    .o_level(level1), .o_overflow(ovf1), .o_underflow(unf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         wr;
    bit         rd;
    bit         fl;
    bit         clr;
    logic [7:0] wd;
    int         lvl;
    bit         rv;
    logic [7:0] rdat;
    bit         ovf;
    bit         unf;
  } vec_t;

  vec_t tbl[$];

  // Queue model of the FIFO contents and registered read side.
  logic [7:0] mq[$];
  bit         m_ovf, m_unf, m_rv;
  logic [7:0] m_rd;

  function automatic vec_t mk(bit wr, bit rd, bit fl, bit clr, logic [7:0] wd, int lvl,
                              bit rv, logic [7:0] rdat, bit ovf, bit unf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.fl = fl; v.clr = clr; v.wd = wd; v.lvl = lvl;
    v.rv = rv; v.rdat = rdat; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit wr, input bit rd, input bit fl, input bit clr,
                       input logic [7:0] wd);
    wr_en = wr; rd_en = rd; flush = fl; clr_err = clr; wr_data = wd;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_status(input string tag, input int lvl);
    chk({tag, " level"}, 32'(level0), lvl);
    chk({tag, " empty"}, 32'(empty0), 32'(lvl == 0));
    chk({tag, " full"}, 32'(full0), 32'(lvl == DEPTH));
    chk({tag, " almost_empty"}, 32'(ae0), 32'(lvl <= AEL));
    chk({tag, " almost_full"}, 32'(af0), 32'(lvl >= AFL));
  endtask

  task automatic chk_reset(input string tag);
    chk_status(tag, 0);
    chk({tag, " rd_data"}, 32'(rd_data0), 0);
    chk({tag, " rd_valid"}, 32'(rd_valid0), 0);
    chk({tag, " overflow"}, 32'(ovf0), 0);
    chk({tag, " underflow"}, 32'(unf0), 0);
  endtask

  task automatic model_step(input bit wr, input bit rd, input bit fl, input bit clr,
                            input logic [7:0] wd);
    bit full, empty;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    m_rv  = 1'b0;
    if (fl) begin
      mq.delete();
      m_ovf = m_ovf && !clr;
      m_unf = m_unf && !clr;
    end else begin
      m_ovf = (wr && full) || (m_ovf && !clr);
      m_unf = (rd && empty) || (m_unf && !clr);
      if (rd && !empty) begin
        m_rd = mq.pop_front();
        m_rv = 1'b1;
      end
      if (wr && !full) mq.push_back(wd);
    end
  endtask

  task automatic chk_model(input string tag);
    int sz;
    sz = mq.size();
    chk_status(tag, sz);
    chk({tag, " overflow"}, 32'(ovf0), 32'(m_ovf));
    chk({tag, " underflow"}, 32'(unf0), 32'(m_unf));
    chk({tag, " rd_valid"}, 32'(rd_valid0), 32'(m_rv));
    if (m_rv) chk({tag, " rd_data"}, 32'(rd_data0), 32'(m_rd));
    chk({tag, " fwft level"}, 32'(level1), sz);
    chk({tag, " fwft overflow"}, 32'(ovf1), 32'(m_ovf));
    chk({tag, " fwft underflow"}, 32'(unf1), 32'(m_unf));
    chk({tag, " fwft rd_valid"}, 32'(rd_valid1), 32'(sz != 0));
    if (sz != 0) chk({tag, " fwft rd_data"}, 32'(rd_data1), 32'(mq[0]));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    reset = 1'b1;
    cycle();
    cycle();
    chk_reset("reset");
    chk("reset fwft rd_valid", 32'(rd_valid1), 0);
    chk("reset fwft empty", 32'(empty1), 1);
    reset = 1'b0;

    // FWFT: head visible the cycle after a push into an empty FIFO.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("fwft rd_valid", 32'(rd_valid1), 1);
    chk("fwft rd_data", 32'(rd_data1), 32'h0000_00A5);
    chk("fwft empty", 32'(empty1), 0);
    cycle();
    chk("fwft hold rd_data", 32'(rd_data1), 32'h0000_00A5);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("fwft consumed empty", 32'(empty1), 1);
    chk("fwft consumed rd_valid", 32'(rd_valid1), 0);
    chk("reg-read pop rd_valid", 32'(rd_valid0), 1);
    chk("reg-read pop rd_data", 32'(rd_data0), 32'h0000_00A5);

    // Directed table: fill/drain, overflow, simultaneous push/pop, thresholds.
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'(i), i + 1, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 16, 1'b0, 8'h00, 1'b1, 1'b0));
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 15 - i, 1'b1, 8'(i), 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h00, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h10 + i), i + 1, 1'b0, 8'h00, 1'b0, 1'b0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h20 + i), 5, 1'b1,
                       (i < 5) ? 8'(8'h10 + i) : 8'(8'h20 + i - 5), 1'b0, 1'b0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4 - i, 1'b1, 8'(8'h25 + i), 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h30, 1, 1'b0, 8'h00, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h30, 1'b0, 1'b1));

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("row%0d", i);
      drive(tbl[i].wr, tbl[i].rd, tbl[i].fl, tbl[i].clr, tbl[i].wd);
      cycle();
      chk_status(tag, tbl[i].lvl);
      chk({tag, " rd_valid"}, 32'(rd_valid0), 32'(tbl[i].rv));
      if (tbl[i].rv) chk({tag, " rd_data"}, 32'(rd_data0), 32'(tbl[i].rdat));
      chk({tag, " overflow"}, 32'(ovf0), 32'(tbl[i].ovf));
      chk({tag, " underflow"}, 32'(unf0), 32'(tbl[i].unf));
    end

    // Flush beats push/pop and raises no error; clr_err loses to a new error.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    cycle();
    chk("clr setup underflow", 32'(unf0), 0);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h50 + i));
      cycle();
    end
    chk_status("pre-flush", 9);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h77);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk_status("flush", 0);
    chk("flush rd_valid", 32'(rd_valid0), 0);
    chk("flush overflow", 32'(ovf0), 0);
    chk("flush underflow", 32'(unf0), 0);
    chk("flush fwft level", 32'(level1), 0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    cycle();
    chk("clr+underflow sticky", 32'(unf0), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("clr alone underflow", 32'(unf0), 0);

    // Asynchronous reset between edges with a pop result in flight.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h40 + i));
      cycle();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h47);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk_status("pre-reset", 7);
    chk("pre-reset rd_valid", 32'(rd_valid0), 1);
    chk("pre-reset rd_data", 32'(rd_data0), 32'h0000_0040);
    #2;
    reset = 1'b1;
    #1;
    chk_reset("async reset");
    #1;
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
    cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("post-reset rd_valid", 32'(rd_valid0), 1);
    chk("post-reset rd_data", 32'(rd_data0), 32'h0000_003C);
    chk_status("post-reset", 0);

    // Randomized run against the queue model, biased to visit full and empty.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rv  = 1'b0;
    m_rd  = 8'h00;
    for (int blk = 0; blk < 12; blk++) begin
      int unsigned pw;
      pw = (blk % 3 == 0) ? 85 : ((blk % 3 == 1) ? 15 : 50);
      for (int c = 0; c < 50; c++) begin
        bit         wr, rd, fl, clr;
        logic [7:0] wd;
        wr  = ($urandom_range(99) < pw);
        rd  = ($urandom_range(99) < (100 - pw));
        fl  = ($urandom_range(63) == 0);
        clr = ($urandom_range(15) == 0);
        wd  = 8'($urandom);
        drive(wr, rd, fl, clr, wd);
        model_step(wr, rd, fl, clr, wd);
        cycle();
        chk_model($sformatf("rand b%0d c%0d", blk, c));
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
